csr_wr_unit: RTL and testbench

- Write-side companion to the core's CSR read path.
- Executes Zicsr instructions CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI and CSRRCI against a small machine-mode CSR file, using a request/response handshake with the execute stage.
- Owns the writable 64-bit mcycle/minstret counters and their read-only user aliases, and returns the old CSR value for rd.

---
 rtl/csr_wr_unit.sv | 188 ++++++++++++++++++
 tb/tb_csr_wr_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_wr_unit.sv
// Write side of the machine-mode CSR file: executes Zicsr read-modify-write
// requests in a three-state IDLE/READ/WRITE sequence and owns mcycle/minstret.
module csr_wr_unit #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_adr,
    input  logic [31:0] src,
    input  logic        src_is_zero_reg,
    input  logic        retire,
    output logic        rsp_valid,
    output logic [31:0] rd_val,
    output logic        illegal,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds it stable until then. rsp_valid is a one-cycle pulse
    // with no back-pressure; rd_val/illegal hold until the next pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [11:0] adr_q, adr_d;
    logic [31:0] src_q, src_d;
    logic        zero_q, zero_d;
    logic [31:0] rd_val_q, rd_val_d;
    logic        illegal_q, illegal_d;
    logic        wen_q, wen_d;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] rdata;
    logic        mapped;
    logic        bad_funct3;
    logic        wants_write;
    logic        fault;
    logic [31:0] new_val;

    always_comb begin
        rdata  = 32'h0;
        mapped = 1'b1;
        case (adr_q)
            12'h300:          rdata = mstatus_q;
            12'h305:          rdata = mtvec_q;
            12'h340:          rdata = mscratch_q;
            12'h341:          rdata = mepc_q;
            12'h342:          rdata = mcause_q;
            12'hB00, 12'hC00: rdata = mcycle_q[31:0];
            12'hB80, 12'hC80: rdata = mcycle_q[63:32];
            12'hB02, 12'hC02: rdata = minstret_q[31:0];
            12'hB82, 12'hC82: rdata = minstret_q[63:32];
            12'hF14:          rdata = HART_ID;
            default:          mapped = 1'b0;
        endcase
    end

    // RS/RC forms with a zero source are pure reads, so they may target read-only CSRs.
    always_comb begin
        bad_funct3  = (funct3_q == 3'b000) || (funct3_q == 3'b100);
        wants_write = (funct3_q == 3'b001) || (funct3_q == 3'b101) || !zero_q;
        fault       = !mapped || bad_funct3 || (wants_write && (adr_q[11:10] == 2'b11));
    end

    always_comb begin
        case (funct3_q)
            3'b001, 3'b101: new_val = src_q;
            3'b010, 3'b110: new_val = rd_val_q | src_q;
            3'b011, 3'b111: new_val = rd_val_q & ~src_q;
            default:        new_val = rd_val_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        adr_d       = adr_q;
        src_d       = src_q;
        zero_d      = zero_q;
        rd_val_d    = rd_val_q;
        illegal_d   = illegal_q;
        wen_d       = wen_q;
        mstatus_d   = mstatus_q;
        mtvec_d     = mtvec_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mcycle_d    = mcycle_q + 64'd1;
        minstret_d  = minstret_q + {63'd0, retire};
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = funct3;
                    adr_d    = csr_adr;
                    src_d    = src;
                    zero_d   = src_is_zero_reg;
                    state_d  = READ;
                end
            end
            READ: begin
                rd_val_d  = fault ? 32'h0 : rdata;
                illegal_d = fault;
                wen_d     = wants_write && !fault;
                state_d   = WRITE;
            end
            WRITE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
                if (wen_q) begin
                    // A counter write replaces that cycle's increment/retire.
                    case (adr_q)
                        12'h300: mstatus_d  = new_val & 32'h0000_0088;
                        12'h305: mtvec_d    = {new_val[31:2], 2'b00};
                        12'h340: mscratch_d = new_val;
                        12'h341: mepc_d     = {new_val[31:2], 2'b00};
                        12'h342: mcause_d   = new_val;
                        12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
                        12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
                        12'hB02: minstret_d = {minstret_q[63:32], new_val};
                        12'hB82: minstret_d = {new_val, minstret_q[31:0]};
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            adr_q      <= 12'h000;
            src_q      <= 32'h0;
            zero_q     <= 1'b0;
            rd_val_q   <= 32'h0;
            illegal_q  <= 1'b0;
            wen_q      <= 1'b0;
            mstatus_q  <= 32'h0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            adr_q      <= adr_d;
            src_q      <= src_d;
            zero_q     <= zero_d;
            rd_val_q   <= rd_val_d;
            illegal_q  <= illegal_d;
            wen_q      <= wen_d;
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign rd_val    = rd_val_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_csr_wr_unit.sv
// Directed bench for csr_wr_unit: each task drives one scenario and checks
// hand-computed rd_val/illegal/latency/counter values inline.
module tb_csr_wr_unit;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_adr;
  logic [31:0] src;
  logic        src_is_zero_reg;
  logic        retire;
  logic        rsp_valid;
  logic [31:0] rd_val;
  logic        illegal;
  logic [1:0]  dbg_state;

  int checks = 0;
  int fails = 0;

  logic [31:0] got_rd;
  logic        got_ill;
  int          got_lat;

  csr_wr_unit #(
    .HART_ID(32'h0000_0003),
    .MTVEC_RESET(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .funct3(funct3),
    .csr_adr(csr_adr),
    .src(src),
    .src_is_zero_reg(src_is_zero_reg),
    .retire(retire),
    .rsp_valid(rsp_valid),
    .rd_val(rd_val),
    .illegal(illegal),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request; lat counts cycles from the accepting IDLE cycle to the rsp_valid cycle.
  task automatic csr_op(input logic [2:0] f3, input logic [11:0] adr, input logic [31:0] s,
                        input logic z, output logic [31:0] rd, output logic ill, output int lat);
    int budget;
    @(negedge clk);
    req_valid = 1'b1;
    funct3 = f3;
    csr_adr = adr;
    src = s;
    src_is_zero_reg = z;
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (lat >= 10) begin
      checks++;
      fails++;
      $display("FAIL rsp_timeout: rsp_valid not seen within 10 cycles for adr %h", adr);
    end
    rd = rd_val;
    ill = illegal;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    funct3 = 3'b000;
    csr_adr = 12'h000;
    src = 32'h0;
    src_is_zero_reg = 1'b0;
    retire = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rd_val !== 32'h0) begin fails++; $display("FAIL reset_rd_val: got %h required 0", rd_val); end
    checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b required 0", illegal); end
    checks++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    rst_n = 1'b1;
    csr_op(3'b010, 12'h305, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0100) begin fails++; $display("FAIL reset_mtvec: got %h required 00000100", got_rd); end
    csr_op(3'b010, 12'h342, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0) begin fails++; $display("FAIL reset_mcause: got %h required 0", got_rd); end
  endtask

  task automatic test_mscratch();
    csr_op(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0) begin fails++; $display("FAIL mscratch_rw_old: got %h required 0", got_rd); end
    checks++; if (got_lat !== 2) begin fails++; $display("FAIL mscratch_rw_latency: got %0d required 2", got_lat); end
    checks++; if (got_ill !== 1'b0) begin fails++; $display("FAIL mscratch_rw_illegal: got %b required 0", got_ill); end
    csr_op(3'b010, 12'h340, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mscratch_rs_old: got %h required deadbeef", got_rd); end
    checks++; if (got_lat !== 2) begin fails++; $display("FAIL mscratch_rs_latency: got %0d required 2", got_lat); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsp_pulse_width: got %b required 0", rsp_valid); end
    checks++; if (rd_val !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_val_hold: got %h required deadbeef", rd_val); end
    csr_op(3'b010, 12'h340, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mscratch_unchanged: got %h required deadbeef", got_rd); end
  endtask

  task automatic test_mstatus();
    csr_op(3'b110, 12'h300, 32'h0000_001F, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0) begin fails++; $display("FAIL mstatus_rsi_old: got %h required 0", got_rd); end
    csr_op(3'b010, 12'h300, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0008) begin fails++; $display("FAIL mstatus_after_rsi: got %h required 00000008", got_rd); end
    csr_op(3'b011, 12'h300, 32'hFFFF_FFFF, 1'b0, got_rd, got_ill, got_lat);
    csr_op(3'b010, 12'h300, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0) begin fails++; $display("FAIL mstatus_after_rc: got %h required 0", got_rd); end
    csr_op(3'b001, 12'h300, 32'hFFFF_FFFF, 1'b0, got_rd, got_ill, got_lat);
    csr_op(3'b010, 12'h300, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0088) begin fails++; $display("FAIL mstatus_mask: got %h required 00000088", got_rd); end
  endtask

  task automatic test_masks();
    csr_op(3'b001, 12'h305, 32'hFFFF_FFFF, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0100) begin fails++; $display("FAIL mtvec_old: got %h required 00000100", got_rd); end
    csr_op(3'b010, 12'h305, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'hFFFF_FFFC) begin fails++; $display("FAIL mtvec_mask: got %h required fffffffc", got_rd); end
    csr_op(3'b001, 12'h341, 32'h0000_1237, 1'b0, got_rd, got_ill, got_lat);
    csr_op(3'b010, 12'h341, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_1234) begin fails++; $display("FAIL mepc_mask: got %h required 00001234", got_rd); end
    csr_op(3'b101, 12'h342, 32'h0000_001B, 1'b0, got_rd, got_ill, got_lat);
    csr_op(3'b010, 12'h342, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_001B) begin fails++; $display("FAIL mcause_rwi: got %h required 0000001b", got_rd); end
    csr_op(3'b010, 12'hF14, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0003 || got_ill !== 1'b0) begin fails++; $display("FAIL mhartid_read: got %h/%b required 00000003/0", got_rd, got_ill); end
    csr_op(3'b001, 12'hF14, 32'h0000_0007, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_ill !== 1'b1 || got_rd !== 32'h0) begin fails++; $display("FAIL mhartid_write: got %h/%b required 00000000/1", got_rd, got_ill); end
  endtask

  task automatic test_illegal();
    csr_op(3'b000, 12'h340, 32'h1111_1111, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_ill !== 1'b1 || got_rd !== 32'h0) begin fails++; $display("FAIL funct3_000: got %h/%b required 00000000/1", got_rd, got_ill); end
    csr_op(3'b100, 12'h340, 32'h2222_2222, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_ill !== 1'b1 || got_rd !== 32'h0) begin fails++; $display("FAIL funct3_100: got %h/%b required 00000000/1", got_rd, got_ill); end
    csr_op(3'b010, 12'h123, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_ill !== 1'b1 || got_rd !== 32'h0) begin fails++; $display("FAIL unmapped: got %h/%b required 00000000/1", got_rd, got_ill); end
    csr_op(3'b010, 12'h340, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'hDEAD_BEEF || got_ill !== 1'b0) begin fails++; $display("FAIL illegal_no_write: got %h/%b required deadbeef/0", got_rd, got_ill); end
  endtask

  // mcycle low is written to FFFFFFFE at the end of cycle W; in cycle W+k it reads FFFFFFFE+(k-1).
  task automatic test_mcycle();
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFE, 1'b0, got_rd, got_ill, got_lat);
    repeat (5) @(negedge clk);
    csr_op(3'b010, 12'hC80, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0001) begin fails++; $display("FAIL mcycle_carry_high: got %h required 00000001", got_rd); end
    csr_op(3'b010, 12'hC00, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0000_0007) begin fails++; $display("FAIL mcycle_low_wrap: got %h required 00000007", got_rd); end
    csr_op(3'b001, 12'hC00, 32'h0000_0005, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_ill !== 1'b1 || got_rd !== 32'h0) begin fails++; $display("FAIL alias_write: got %h/%b required 00000000/1", got_rd, got_ill); end
    csr_op(3'b010, 12'hC00, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_ill !== 1'b0 || got_rd !== 32'h0000_000D) begin fails++; $display("FAIL alias_read: got %h/%b required 0000000d/0", got_rd, got_ill); end
  endtask

  task automatic test_minstret();
    @(negedge clk);
    retire = 1'b1;
    repeat (10) @(negedge clk);
    retire = 1'b0;
    csr_op(3'b010, 12'hB02, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'd10) begin fails++; $display("FAIL minstret_count: got %0d required 10", got_rd); end
    retire = 1'b1;
    csr_op(3'b001, 12'hB02, 32'd100, 1'b0, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'd12) begin fails++; $display("FAIL minstret_old: got %0d required 12", got_rd); end
    @(posedge clk);
    #1 retire = 1'b0;
    @(negedge clk);
    retire = 1'b1;
    repeat (3) @(negedge clk);
    retire = 1'b0;
    csr_op(3'b010, 12'hB02, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'd103) begin fails++; $display("FAIL minstret_write_wins: got %0d required 103", got_rd); end
    csr_op(3'b010, 12'hC82, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0) begin fails++; $display("FAIL minstret_high: got %h required 0", got_rd); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    req_valid = 1'b1;
    funct3 = 3'b001;
    csr_adr = 12'h341;
    src = 32'h5555_0000;
    src_is_zero_reg = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL mid_in_read: got %0d required 1", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b required 1", req_ready); end
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) pulses++;
    checks++; if (pulses !== 0) begin fails++; $display("FAIL mid_no_rsp: got %0d pulses required 0", pulses); end
    csr_op(3'b010, 12'h341, 32'h0, 1'b1, got_rd, got_ill, got_lat);
    checks++; if (got_rd !== 32'h0) begin fails++; $display("FAIL mid_mepc: got %h required 0", got_rd); end
  endtask

  initial begin
    test_reset();
    test_mscratch();
    test_mstatus();
    test_masks();
    test_illegal();
    test_mcycle();
    test_minstret();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
